// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side bundle between ID and hazard_stall_ctrl: ID operand/destination info in, stall/bubble/forward/halt out.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_wr_en;
  logic             id_is_load;
  logic             id_is_halt;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_rs_a;
  logic             id_use_a;
  logic [REG_W-1:0] id_rs_b;
  logic             id_use_b;
  logic             ex_flush;
  logic             stall;
  logic             ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwd_cnt;

  modport master (
    output id_valid, id_wr_en, id_is_load, id_is_halt, id_rd,
           id_rs_a, id_use_a, id_rs_b, id_use_b, ex_flush,
    input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, halted, stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_valid, id_wr_en, id_is_load, id_is_halt, id_rd,
           id_rs_a, id_use_a, id_rs_b, id_use_b, ex_flush,
    output stall, ex_bubble, fwd_a_sel, fwd_b_sel, halted, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: EX/MEM destination tracker producing forward selects, load-use stalls, flush bubbles and HLT drain.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/forward performance counters.
module hazard_stall_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             ld;
    logic             hlt;
    logic [REG_W-1:0] rd;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam slot_t SLOT_EMPTY = {(REG_W + 4){1'b0}};

  slot_t      ex_r;
  slot_t      mem_r;
  slot_t      id_entry_s;
  slot_t      ex_next_s;
  state_t     state_r;
  logic       halted_r;
  logic       dep_ex_a_s;
  logic       dep_ex_b_s;
  logic       dep_mem_a_s;
  logic       dep_mem_b_s;
  logic       load_use_s;
  logic       stall_s;
  logic       ex_bubble_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  function automatic logic dep_f(input logic valid, input logic use_op,
                                 input logic [REG_W-1:0] rs, input slot_t s);
    return valid & use_op & s.v & s.wr & (s.rd == rs);
  endfunction

  // Nearest non-load producer wins; load results only exist at WB and are never forwarded.
  function automatic logic [1:0] fwd_f(input logic dep_ex, input logic dep_mem,
                                       input slot_t ex, input slot_t mem);
    logic [1:0] sel;
    if (dep_ex && !ex.ld) begin
      sel = 2'b01;
    end else if (dep_mem && !mem.ld) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Dependency check, forward selects, stall/bubble decision and next EX slot contents.
  always_comb begin
    stall_s     = 1'b1;
    dep_ex_a_s  = dep_f(bus.id_valid, bus.id_use_a, bus.id_rs_a, ex_r);
    dep_ex_b_s  = dep_f(bus.id_valid, bus.id_use_b, bus.id_rs_b, ex_r);
    dep_mem_a_s = dep_f(bus.id_valid, bus.id_use_a, bus.id_rs_a, mem_r);
    dep_mem_b_s = dep_f(bus.id_valid, bus.id_use_b, bus.id_rs_b, mem_r);
    fwd_a_s     = fwd_f(dep_ex_a_s, dep_mem_a_s, ex_r, mem_r);
    fwd_b_s     = fwd_f(dep_ex_b_s, dep_mem_b_s, ex_r, mem_r);
    load_use_s  = (ex_r.ld & (dep_ex_a_s | dep_ex_b_s)) |
                  (mem_r.ld & (dep_mem_a_s | dep_mem_b_s));
    case (state_r)
      ST_RUN:    stall_s = ~bus.ex_flush & load_use_s;
      ST_DRAIN:  stall_s = ~bus.ex_flush;
      ST_HALTED: stall_s = 1'b1;
      default:   stall_s = 1'b1;
    endcase
    ex_bubble_s   = ~rst_n | stall_s | bus.ex_flush | (state_r != ST_RUN);
    id_entry_s.v   = bus.id_valid & ~stall_s & ~bus.ex_flush;
    id_entry_s.wr  = bus.id_wr_en;
    id_entry_s.ld  = bus.id_is_load;
    id_entry_s.hlt = bus.id_is_halt;
    id_entry_s.rd  = bus.id_rd;
    if (ex_bubble_s) begin
      ex_next_s = SLOT_EMPTY;
    end else begin
      ex_next_s = id_entry_s;
    end
  end

  // Tracker shift: ID entry (or bubble) into EX, EX into MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= SLOT_EMPTY;
      mem_r <= SLOT_EMPTY;
    end else begin
      ex_r  <= ex_next_s;
      mem_r <= ex_r;
    end
  end

  // HLT drain sequencing; HALTED is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          halted_r <= 1'b0;
          if (bus.id_valid && bus.id_is_halt && !stall_s && !bus.ex_flush) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (bus.ex_flush) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else if (!ex_r.v && mem_r.v && mem_r.hlt) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_DRAIN;
            halted_r <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_r  <= ST_HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] fwd_cnt_r;

  // Saturating load-use stall and forwarding-activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      fwd_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (state_r == ST_RUN) && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (((fwd_a_s | fwd_b_s) != 2'b00) && (fwd_cnt_r != {CNT_W{1'b1}})) begin
        fwd_cnt_r <= fwd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fwd_cnt_r <= fwd_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.fwd_cnt   = fwd_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.fwd_cnt   = {CNT_W{1'b0}};
`endif

  assign bus.stall     = stall_s;
  assign bus.ex_bubble = ex_bubble_s;
  assign bus.fwd_a_sel = fwd_a_s;
  assign bus.fwd_b_sel = fwd_b_s;
  assign bus.halted    = halted_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: forwarding, load-use stall, flush, HLT drain, reset and counter saturation.
module tb_hazard_stall_ctrl;
  localparam int REG_W = 3;
  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic wr, input logic ld, input logic hlt,
                     input logic [2:0] rd, input logic [2:0] ra, input logic ua,
                     input logic [2:0] rb, input logic ub, input logic fl);
    bus.id_valid   = v;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.id_is_halt = hlt;
    bus.id_rd      = rd;
    bus.id_rs_a    = ra;
    bus.id_use_a   = ua;
    bus.id_rs_b    = rb;
    bus.id_use_b   = ub;
    bus.ex_flush   = fl;
    #2;
  endtask

  task automatic nop();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop();
    // reset state
    chk1("rst_stall", bus.stall, 1'b0);
    chk1("rst_bubble", bus.ex_bubble, 1'b1);
    chk2("rst_fwd_a", bus.fwd_a_sel, 2'b00);
    chk2("rst_fwd_b", bus.fwd_b_sel, 2'b00);
    chk1("rst_halted", bus.halted, 1'b0);
    chkc("rst_stall_cnt", bus.stall_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD r1 then ADD r2,r1 -> EX forward on A
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    chk1("add1_stall", bus.stall, 1'b0);
    chk1("add1_bubble", bus.ex_bubble, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    chk2("ex_fwd_a", bus.fwd_a_sel, 2'b01);
    chk2("ex_fwd_b_none", bus.fwd_b_sel, 2'b00);
    chk1("ex_fwd_stall", bus.stall, 1'b0);
    tick();

    // ADD r3; NOP; SUB r4,r7,r3 -> MEM forward on B
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd7, 1'b1, 3'd3, 1'b1, 1'b0);
    chk2("mem_fwd_b", bus.fwd_b_sel, 2'b10);
    chk2("mem_fwd_a_none", bus.fwd_a_sel, 2'b00);
    tick();

    // ADD r3 in both EX and MEM -> nearest (EX) wins
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
    chk2("nearest_wins", bus.fwd_a_sel, 2'b01);
    tick();
    nop();
    chkc("fwd_cnt_3", bus.fwd_cnt, PERF ? 4'd3 : 4'd0);
    tick();
    nop();
    tick();

    // LD r5 then ADD r6,r5 -> two stall cycles
    drv(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk1("ld_issue_stall", bus.stall, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    chk1("lu_stall_1", bus.stall, 1'b1);
    chk1("lu_bubble_1", bus.ex_bubble, 1'b1);
    chk2("lu_no_fwd_ld", bus.fwd_a_sel, 2'b00);
    tick();
    chk1("lu_stall_2", bus.stall, 1'b1);
    chk1("lu_bubble_2", bus.ex_bubble, 1'b1);
    tick();
    chk1("lu_stall_end", bus.stall, 1'b0);
    chk1("lu_bubble_end", bus.ex_bubble, 1'b0);
    chk2("lu_fwd_a_end", bus.fwd_a_sel, 2'b00);
    chk2("lu_fwd_b_end", bus.fwd_b_sel, 2'b00);
    chkc("lu_stall_cnt", bus.stall_cnt, PERF ? 4'd2 : 4'd0);
    tick();

    // load-use hazard coinciding with flush: flush wins, EX left empty
    drv(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1);
    chk1("flush_stall", bus.stall, 1'b0);
    chk1("flush_bubble", bus.ex_bubble, 1'b1);
    tick();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    chk2("flush_ex_empty", bus.fwd_a_sel, 2'b00);
    chk1("flush_after_stall", bus.stall, 1'b0);
    chk1("flush_after_bubble", bus.ex_bubble, 1'b0);
    tick();
    nop();
    chkc("flush_stall_cnt", bus.stall_cnt, PERF ? 4'd2 : 4'd0);
    tick();
    nop();
    tick();

    // HLT -> two DRAIN cycles -> HALTED
    drv(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk1("hlt_issue_stall", bus.stall, 1'b0);
    chk1("hlt_issue_bubble", bus.ex_bubble, 1'b0);
    tick();
    nop();
    chk1("drain1_stall", bus.stall, 1'b1);
    chk1("drain1_bubble", bus.ex_bubble, 1'b1);
    chk1("drain1_halted", bus.halted, 1'b0);
    tick();
    chk1("drain2_stall", bus.stall, 1'b1);
    chk1("drain2_halted", bus.halted, 1'b0);
    tick();
    chk1("halted_set", bus.halted, 1'b1);
    chk1("halted_stall", bus.stall, 1'b1);
    tick();
    tick();
    chk1("halted_hold", bus.halted, 1'b1);
    chk1("halted_stall_hold", bus.stall, 1'b1);

    // reset out of HALTED, then reset in the middle of a drain
    rst_n = 1'b0;
    #1;
    chk1("rst_halted_clr", bus.halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    nop();
    chk1("middrain_stall", bus.stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("middrain_rst_stall", bus.stall, 1'b0);
    chk1("middrain_rst_bubble", bus.ex_bubble, 1'b1);
    chk1("middrain_rst_halted", bus.halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nop();
    chk1("post_rst_run_stall", bus.stall, 1'b0);
    chk1("post_rst_run_bubble", bus.ex_bubble, 1'b0);
    tick();
    tick();
    tick();
    chk1("post_rst_not_halted", bus.halted, 1'b0);
    chkc("post_rst_stall_cnt", bus.stall_cnt, 4'd0);

    // 10 LD/use pairs = 20 stall cycles -> counter saturates at 15
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
      tick();
      tick();
      tick();
    end
    nop();
    chkc("stall_cnt_sat", bus.stall_cnt, PERF ? 4'd15 : 4'd0);
    chk1("sat_run_stall", bus.stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
